// File: rtl/music_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | music_pkg: shared state and play-mode encodings for the sequencer.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package music_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [1:0] MODE_LOOP    = 2'b00;
  localparam logic [1:0] MODE_ONESHOT = 2'b01;
  localparam logic [1:0] MODE_AUTO    = 2'b10;

endpackage
`default_nettype wire

// File: rtl/music_seg_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | music_seg_cnt: segment address counter with end-of-segment compare.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module music_seg_cnt #(
  parameter int AW = 10
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] start,
  input  logic [AW-1:0] end_eff,
  output logic [AW-1:0] cnt,
  output logic          at_end
);

  logic [AW-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= start;
    end else if (inc) begin
      r_cnt <= r_cnt + AW'(1);
    end
  end

  // Unsigned >= so an end address of all-ones is reached without wrapping.
  assign at_end = (r_cnt >= end_eff);
  assign cnt    = r_cnt;

endmodule
`default_nettype wire

// File: rtl/music_addr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | music_addr_seq: ROM address sequencer with loop / one-shot /         |
// | auto-advance modes, pause and restart.                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module music_addr_seq
  import music_pkg::*;
#(
  parameter int AW        = 10,
  parameter int SW        = 4,
  parameter int NUM_SONGS = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          EN,
  input  logic          TICK,
  input  logic          PAUSE,
  input  logic          RESTART,
  input  logic [1:0]    MODE,
  input  logic [SW-1:0] SONG_SEL,
  input  logic [AW-1:0] START_ADDR,
  input  logic [AW-1:0] END_ADDR,
  output logic [AW-1:0] ADDR,
  output logic [SW-1:0] SONG_CUR,
  output logic          PLAYING,
  output logic          SONG_END,
  output logic          CFG_ERR
);

  localparam logic [SW:0]   c_num_songs = (SW+1)'(NUM_SONGS);
  localparam logic [SW-1:0] c_last_song = SW'(NUM_SONGS - 1);

  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_song_cur, w_song_nxt;
  logic [SW-1:0] r_sel_q, w_sel_nxt;
  logic          r_song_end, w_song_end_nxt;
  logic          r_cfg_err, w_err_set;
  logic          w_load, w_inc, w_at_end;
  logic          w_sel_valid, w_sel_chg, w_bad_seg;
  logic [AW-1:0] w_end_eff;

  assign w_sel_valid = ({1'b0, SONG_SEL} < c_num_songs);
  assign w_sel_chg   = w_sel_valid && (SONG_SEL != r_sel_q);
  // A reversed segment collapses to its start address.
  assign w_bad_seg   = (START_ADDR > END_ADDR);
  assign w_end_eff   = w_bad_seg ? START_ADDR : END_ADDR;

  always_comb begin
    w_state_nxt    = r_state;
    w_song_nxt     = r_song_cur;
    w_sel_nxt      = r_sel_q;
    w_song_end_nxt = 1'b0;
    w_load         = 1'b0;
    w_inc          = 1'b0;
    w_err_set      = EN && !w_sel_valid;
    case (r_state)
      S_IDLE: begin
        if (EN) begin
          w_song_nxt  = w_sel_valid ? SONG_SEL : '0;
          w_sel_nxt   = w_sel_valid ? SONG_SEL : '0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_load      = 1'b1;
        w_err_set   = w_err_set || w_bad_seg;
        w_state_nxt = EN ? S_PLAY : S_IDLE;
      end
      S_PLAY, S_HOLD: begin
        if (!EN) begin
          w_state_nxt = S_IDLE;
        end else if (w_sel_chg) begin
          w_song_nxt  = SONG_SEL;
          w_sel_nxt   = SONG_SEL;
          w_state_nxt = S_LOAD;
        end else if (RESTART) begin
          w_state_nxt = S_LOAD;
        end else if ((r_state == S_PLAY) && TICK && !PAUSE) begin
          if (w_at_end) begin
            w_song_end_nxt = 1'b1;
            case (MODE)
              MODE_ONESHOT: w_state_nxt = S_HOLD;
              MODE_AUTO: begin
                // Auto-advance leaves sel_q alone so it is not seen as a user select.
                w_song_nxt  = (r_song_cur == c_last_song) ? '0 : r_song_cur + SW'(1);
                w_state_nxt = S_LOAD;
              end
              default: w_load = 1'b1;
            endcase
          end else begin
            w_inc = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_song_cur <= '0;
      r_sel_q    <= '0;
      r_song_end <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_song_cur <= w_song_nxt;
      r_sel_q    <= w_sel_nxt;
      r_song_end <= w_song_end_nxt;
      if (w_err_set) r_cfg_err <= 1'b1;
    end
  end

  music_seg_cnt #(
    .AW(AW)
  ) u_seg_cnt (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .load   (w_load),
    .inc    (w_inc),
    .start  (START_ADDR),
    .end_eff(w_end_eff),
    .cnt    (ADDR),
    .at_end (w_at_end)
  );

  assign SONG_CUR = r_song_cur;
  assign PLAYING  = (r_state == S_PLAY) && !PAUSE;
  assign SONG_END = r_song_end;
  assign CFG_ERR  = r_cfg_err;

endmodule
`default_nettype wire
